// File: rtl/totd_pattern_gen_40mhz_if.sv
// Port bundle for the 40 MHz ToTd synthetic-shower pattern generator.
// Provides default widths for ADC_WIDTH and the FD/FN fields when the trigger headers are absent.
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef COMPATIBILITY_TOTD_FD_BITS
`define COMPATIBILITY_TOTD_FD_BITS 8
`endif
`ifndef COMPATIBILITY_TOTD_FN_BITS
`define COMPATIBILITY_TOTD_FN_BITS 4
`endif

interface totd_pattern_gen_40mhz_if #(
    parameter int ADC_WIDTH = `ADC_WIDTH,
    parameter int CNT_BITS  = 8
);
    // START/ABORT are level requests sampled on every CLK120 edge and held as
    // sticky flags until the next bin edge; no ready is returned. BUSY says a
    // pattern is running (a START seen then is dropped); DONE marks its end.
    logic                                    START;
    logic                                    ABORT;
    logic [ADC_WIDTH-1:0]                    BASELINE;
    logic [ADC_WIDTH-1:0]                    AMPLITUDE;
    logic [CNT_BITS-1:0]                     NPULSES;
    logic [CNT_BITS-1:0]                     PULSE_WIDTH;
    logic [CNT_BITS-1:0]                     PULSE_GAP;
    logic [CNT_BITS-1:0]                     TAIL_MAX;
    logic [`COMPATIBILITY_TOTD_FD_BITS-1:0]  FD;
    logic [`COMPATIBILITY_TOTD_FN_BITS-1:0]  FN;
    logic [1:0]                              ENABLE40;
    logic [ADC_WIDTH-1:0]                    ADC;
    logic                                    BUSY;
    logic                                    DONE;
    logic [2:0]                              state_dbg;

    modport master (
        output START, ABORT, BASELINE, AMPLITUDE, NPULSES, PULSE_WIDTH,
               PULSE_GAP, TAIL_MAX, FD, FN,
        input  ENABLE40, ADC, BUSY, DONE, state_dbg
    );

    modport slave (
        input  START, ABORT, BASELINE, AMPLITUDE, NPULSES, PULSE_WIDTH,
               PULSE_GAP, TAIL_MAX, FD, FN,
        output ENABLE40, ADC, BUSY, DONE, state_dbg
    );
endinterface

// File: rtl/totd_pattern_gen_40mhz.sv
// Pulse-train source shaped by the forward FD/FN filter, updated once per 40 MHz bin on CLK120.
// Define TOTD_PATGEN_NOISE_EN to add a 1-LSB LFSR dither bit to ADC.
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef COMPATIBILITY_TOTD_FD_BITS
`define COMPATIBILITY_TOTD_FD_BITS 8
`endif
`ifndef COMPATIBILITY_TOTD_FN_BITS
`define COMPATIBILITY_TOTD_FN_BITS 4
`endif

module totd_pattern_gen_40mhz #(
    parameter int ADC_WIDTH = `ADC_WIDTH,
    parameter int CNT_BITS  = 8
) (
    input logic                    CLK120,
    input logic                    RESET_N,
    totd_pattern_gen_40mhz_if.slave bus
);
    localparam int AW  = ADC_WIDTH + 4;
    localparam int FDW = `COMPATIBILITY_TOTD_FD_BITS;
    localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

    typedef enum logic [2:0] {S_IDLE, S_PULSE, S_GAP, S_TAIL, S_DONE} state_t;

    state_t               st, st_nxt;
    logic [1:0]           ph;
    logic                 bin_edge, start_flag, abort_flag, start_req, abort_req;
    logic [CNT_BITS-1:0]  pulse_cnt, bin_cnt, gap_cnt, tail_cnt;
    logic [CNT_BITS-1:0]  pulse_nxt, bin_nxt, gap_nxt, tail_nxt;
    logic [CNT_BITS-1:0]  width_r, gap_r, tmax_r, width_in;
    logic [ADC_WIDTH-1:0] amp_r, base_r, amp_eff, base_eff, adc_r, adc_nxt;
    logic [AW-1:0]        acc, acc_nxt, src;
    logic [AW+FDW-1:0]    prod, decay;
    logic [AW+FDW:0]      acc_sum;
    logic [AW:0]          adc_sum;
    logic                 load_cfg, done_r, noise_bit;

    assign bin_edge  = (ph == 2'd0);
    assign start_req = start_flag | bus.START;
    assign abort_req = abort_flag | bus.ABORT;
    assign width_in  = (bus.PULSE_WIDTH == '0) ? ONE : bus.PULSE_WIDTH;

    always_comb begin
        st_nxt    = st;
        pulse_nxt = pulse_cnt;
        bin_nxt   = bin_cnt;
        gap_nxt   = gap_cnt;
        tail_nxt  = tail_cnt;
        load_cfg  = 1'b0;
        case (st)
            S_IDLE: begin
                if (start_req && !abort_req) begin
                    if (bus.NPULSES == '0) begin
                        st_nxt = S_DONE;
                    end else begin
                        st_nxt    = S_PULSE;
                        load_cfg  = 1'b1;
                        pulse_nxt = bus.NPULSES;
                        bin_nxt   = width_in;
                    end
                end
            end
            S_PULSE: begin
                if (bin_cnt > ONE) begin
                    bin_nxt = bin_cnt - ONE;
                end else begin
                    pulse_nxt = pulse_cnt - ONE;
                    if (pulse_cnt > ONE) begin
                        if (gap_r == '0) begin
                            bin_nxt = width_r;
                        end else begin
                            st_nxt  = S_GAP;
                            gap_nxt = gap_r;
                        end
                    end else begin
                        st_nxt   = S_TAIL;
                        tail_nxt = ONE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt > ONE) begin
                    gap_nxt = gap_cnt - ONE;
                end else begin
                    st_nxt  = S_PULSE;
                    bin_nxt = width_r;
                end
            end
            S_TAIL: begin
                if (acc == '0 || tail_cnt >= tmax_r) st_nxt = S_DONE;
                else                                 tail_nxt = tail_cnt + ONE;
            end
            S_DONE:  st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
        // DONE is left alone so an abort there cannot produce a second DONE pulse.
        if (abort_req && st != S_IDLE && st != S_DONE) st_nxt = S_DONE;
    end

    // Config comes straight from the ports on the accepting edge, from the latches afterwards.
    assign amp_eff  = (st == S_IDLE) ? bus.AMPLITUDE : amp_r;
    assign base_eff = load_cfg ? bus.BASELINE : base_r;
    assign src      = (st_nxt == S_PULSE) ? {4'b0000, amp_eff} : '0;
    assign prod     = {{FDW{1'b0}}, acc} * {{AW{1'b0}}, bus.FD};
    assign decay    = prod >> bus.FN;
    assign acc_sum  = {1'b0, decay} + {{(FDW+1){1'b0}}, src};

    always_comb begin
        acc_nxt = '0;
        if (st_nxt != S_IDLE && st_nxt != S_DONE)
            acc_nxt = (|acc_sum[AW+FDW:AW]) ? {AW{1'b1}} : acc_sum[AW-1:0];
    end

`ifdef TOTD_PATGEN_NOISE_EN
    logic [15:0] lfsr;
    assign noise_bit = lfsr[0];
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N)      lfsr <= 16'hACE1;
        else if (bin_edge) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`else
    assign noise_bit = 1'b0;
`endif

    assign adc_sum = {5'b00000, base_eff} + {1'b0, acc_nxt} + {{AW{1'b0}}, noise_bit};
    assign adc_nxt = (|adc_sum[AW:ADC_WIDTH]) ? {ADC_WIDTH{1'b1}} : adc_sum[ADC_WIDTH-1:0];

    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            st         <= S_IDLE;
            ph         <= 2'd0;
            start_flag <= 1'b0;
            abort_flag <= 1'b0;
            pulse_cnt  <= '0;
            bin_cnt    <= '0;
            gap_cnt    <= '0;
            tail_cnt   <= '0;
            width_r    <= '0;
            gap_r      <= '0;
            tmax_r     <= '0;
            amp_r      <= '0;
            base_r     <= '0;
            acc        <= '0;
            adc_r      <= '0;
            done_r     <= 1'b0;
        end else begin
            ph     <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
            done_r <= 1'b0;
            if (bin_edge) begin
                st         <= st_nxt;
                pulse_cnt  <= pulse_nxt;
                bin_cnt    <= bin_nxt;
                gap_cnt    <= gap_nxt;
                tail_cnt   <= tail_nxt;
                acc        <= acc_nxt;
                adc_r      <= adc_nxt;
                start_flag <= 1'b0;
                abort_flag <= 1'b0;
                done_r     <= (st_nxt == S_DONE);
                if (load_cfg) begin
                    width_r <= width_in;
                    gap_r   <= bus.PULSE_GAP;
                    tmax_r  <= bus.TAIL_MAX;
                    amp_r   <= bus.AMPLITUDE;
                    base_r  <= bus.BASELINE;
                end
            end else begin
                start_flag <= start_flag | bus.START;
                abort_flag <= abort_flag | bus.ABORT;
            end
        end
    end

    assign bus.ENABLE40  = ph;
    assign bus.ADC       = adc_r;
    assign bus.BUSY      = (st != S_IDLE);
    assign bus.DONE      = done_r;
    assign bus.state_dbg = st;
endmodule

// File: doc/totd_pattern_gen_40mhz.md
# totd_pattern_gen_40mhz

Synthetic-shower stimulus source for the 40 MHz compatibility ToTd trigger path. Runs a free-running 40 MHz bin phase on CLK120 and drives it out as ENABLE40. Emits a programmable train of rectangular pulses on a single 12-bit ADC channel, shaped by the forward (convolution) form of the FD/FN filter that the ToTd deconvolver removes. Sits in front of the trigger's ADC inputs behind a test mux for built-in self-test and bench calibration of OCCUPANCY, INT and threshold settings.

## Interface
- ADC_WIDTH, 12, sample width (matches `ADC_WIDTH)
- CNT_BITS, 8, width of NPULSES, PULSE_WIDTH, PULSE_GAP, TAIL_MAX
- CLK120  in  1  120 MHz clock
- RESET_N  in  1  reset, asynchronous assert, active-low
- START  in  1  request one pattern; sampled on any CLK120 edge
- ABORT  in  1  terminate pattern; priority over START
- BASELINE  in  ADC_WIDTH  pedestal added to shaped signal
- AMPLITUDE  in  ADC_WIDTH  source height per pulse bin
- NPULSES  in  CNT_BITS  pulses per pattern
- PULSE_WIDTH  in  CNT_BITS  bins per pulse (0 treated as 1)
- PULSE_GAP  in  CNT_BITS  bins between pulses
- TAIL_MAX  in  CNT_BITS  max bins of decay tail after last pulse
- FD  in  `COMPATIBILITY_TOTD_FD_BITS  decay numerator
- FN  in  `COMPATIBILITY_TOTD_FN_BITS  decay shift
- ENABLE40  out  2  bin phase 0,1,2; 0 marks bin update cycle
- ADC  out  ADC_WIDTH  synthetic trace, constant over each 3-clock bin
- BUSY  out  1  high from accepted START until return to IDLE
- DONE  out  1  one-CLK120 pulse on pattern completion or abort

## Operation
- Phase counter PH: 0→1→2→0 every CLK120, never stalls; ENABLE40 = PH.
- All FSM, counter and filter updates occur only on edges where PH == 0 (bin edge). START/ABORT are latched on any edge into sticky flags consumed at the next bin edge.
- Filter: ACC_next = SRC + ((ACC × FD) >> FN); internal width ADC_WIDTH+4; saturates at all-ones. SRC = AMPLITUDE in PULSE state, else 0.
- ADC = min(BASELINE + ACC, 2^ADC_WIDTH−1), registered at the bin edge.
- States:
  - IDLE: ACC = 0; on START flag → PULSE with pulse count = NPULSES, bin count = max(PULSE_WIDTH,1). NPULSES == 0 → DONE directly.
  - PULSE: bin count down; at expiry, pulse count −1; remaining pulses → GAP (or PULSE if PULSE_GAP == 0), else → TAIL.
  - GAP: count PULSE_GAP bins → PULSE.
  - TAIL: SRC = 0; exit to DONE when ACC == 0 or TAIL_MAX bins elapsed.
  - DONE: one bin; DONE output high for the first CLK120 of that bin; ACC cleared; → IDLE.
- ABORT flag at a bin edge, from any non-IDLE state → DONE (ACC cleared immediately). ABORT in IDLE: dropped.
- START while BUSY: ignored, flag cleared. START and ABORT in the same bin: ABORT wins and START is dropped.
- FD ≥ 2^FN is not a supported configuration. The saturation keeps the output bounded; TAIL_MAX guarantees termination.
- Input configuration is sampled at IDLE→PULSE; changes mid-pattern take effect only on the next pattern. FD/FN are the exception: they are live.

## Timing
- Reset values: PH = 0, ENABLE40 = 0, ADC = 0, BUSY = 0, DONE = 0, ACC = 0, state IDLE, flags clear.
- Reset may assert mid-pattern. All state clears asynchronously, and no DONE is produced.
- START latency: first shaped bin (ADC = BASELINE+AMPLITUDE) appears on the first bin edge after START, i.e. 1–3 CLK120 later. BUSY rises on the same edge.
- ADC changes only on bin edges and is held 3 clocks.
- The pattern lasts NPULSES×W + (NPULSES−1)×PULSE_GAP + tail + 1 bins, where W = max(PULSE_WIDTH,1). BUSY falls with the DONE-bin exit edge.

## Configuration
- TOTD_PATGEN_NOISE_EN defined: a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances each bin edge. Bit 0 adds +1 LSB to ADC before saturation, including in IDLE, to exercise threshold edges.
- Not defined: ADC is fully deterministic; there is no LFSR logic.

## Test plan
- After reset release, ENABLE40 cycles 0,1,2. START with BASELINE=50, AMPLITUDE=100, NPULSES=1, PULSE_WIDTH=4, FD=0, TAIL_MAX=10 → ADC = 150 for 4 bins (12 clocks), then 50. DONE pulses once; BUSY spans 6 bins.
- FD=3, FN=2, AMPLITUDE=64, one 1-bin pulse, BASELINE=0 → ADC sequence 64, 48, 36, 27, 20, …, 0, then DONE. When run into the trigger's deconvolver, this yields a single nonzero bin.
- NPULSES=3, PULSE_WIDTH=2, PULSE_GAP=0, FD=0 → 6 contiguous bins at BASELINE+AMPLITUDE; then tail of 0 bins; then DONE.
- BASELINE=4000, AMPLITUDE=4000 → ADC saturates at 4095, with no wrap.
- ABORT in the 2nd pulse bin → next bin edge: ADC = BASELINE, DONE pulses, BUSY falls at the following edge. A START issued while BUSY is ignored.
- NPULSES=0 → DONE within 2 bins, ADC stays at 0 throughout; RESET_N asserted mid-PULSE → all outputs 0 immediately, with no DONE.
